gap_classifier: RTL and testbench

GAP_CLASSIFIER -- requirements
Module: gap_classifier

---
 rtl/gap_classifier.sv | 123 ++++++++++++
 tb/tb_gap_classifier.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/gap_classifier.sv
// gap_classifier: measures the run of spaces between two markers on a
// qualified serial stream and reports the gap length as a registered code.
//
// Ports
//   Clk   : clock, all state updates on the rising edge
//   Rst   : synchronous active-high reset
//   b     : serial data sample
//   en    : sample qualifier, b is consumed only when en=1
//   pol   : marker polarity (marker is b==pol), sampled only while idle
//   o     : gap code, count below MAX_GAP or all-ones when saturated
//   valid : one-cycle strobe qualifying o and sat
//   sat   : gap reached MAX_GAP (0 whenever valid=0)
module gap_classifier #(
  parameter int unsigned GAP_W   = 3,
  parameter int unsigned MAX_GAP = 4,
  parameter int unsigned CHAIN   = 0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             b,
  input  logic             en,
  input  logic             pol,
  output logic [GAP_W-1:0] o,
  output logic             valid,
  output logic             sat
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MARK   = 2'd1,
    GAP    = 2'd2,
    REPORT = 2'd3
  } state_e;

  localparam logic [GAP_W-1:0] MaxCnt = GAP_W'(MAX_GAP);

  state_e           state_q, state_d;
  logic [GAP_W-1:0] cnt_q, cnt_d;
  logic             pol_q, pol_d;
  logic [GAP_W-1:0] o_q, o_d;
  logic             valid_q, valid_d;
  logic             sat_q, sat_d;
  logic             marker_c;

  // Idle uses the live polarity; an open measurement uses the latched one.
  always_comb begin
    marker_c = (state_q == IDLE) ? (b == pol) : (b == pol_q);
  end

  // Next-state, counter and report generation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pol_d   = pol_q;
    o_d     = '0;
    valid_d = 1'b0;
    sat_d   = 1'b0;

    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (marker_c) begin
            state_d = MARK;
            pol_d   = pol;
          end
        end
        MARK: begin
          if (!marker_c) begin
            state_d = GAP;
            cnt_d   = GAP_W'(1);
          end
        end
        GAP: begin
          if (marker_c) begin
            state_d = REPORT;
            valid_d = 1'b1;
            sat_d   = (cnt_q == MaxCnt);
            o_d     = (cnt_q < MaxCnt) ? cnt_q : '1;
          end else if (cnt_q < MaxCnt) begin
            // Saturate so long space runs never wrap.
            cnt_d = cnt_q + GAP_W'(1);
          end
        end
        REPORT: begin
          if (marker_c) begin
            state_d = MARK;
          end else if (CHAIN != 0) begin
            // Closing marker doubles as the opening marker of the next gap.
            state_d = GAP;
            cnt_d   = GAP_W'(1);
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pol_q   <= 1'b1;
      o_q     <= '0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pol_q   <= pol_d;
      o_q     <= o_d;
      valid_q <= valid_d;
      sat_q   <= sat_d;
    end
  end

  assign o     = o_q;
  assign valid = valid_q;
  assign sat   = sat_q;

endmodule

// File: tb/tb_gap_classifier.sv
// Bench for gap_classifier: two instances (CHAIN=0 and CHAIN=1) share one
// input stream; a directed vector table, a chained hand sequence and a
// random run are checked against a measurement-level reference model.
module tb_gap_classifier;

  localparam int MAXG = 4;

  logic       Clk = 1'b0;
  logic       Rst, b, en, pol;
  logic [2:0] o0, o1;
  logic       v0, v1, s0, s1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  gap_classifier #(.GAP_W(3), .MAX_GAP(MAXG), .CHAIN(0)) dut0 (
    .Clk(Clk), .Rst(Rst), .b(b), .en(en), .pol(pol),
    .o(o0), .valid(v0), .sat(s0)
  );

  gap_classifier #(.GAP_W(3), .MAX_GAP(MAXG), .CHAIN(1)) dut1 (
    .Clk(Clk), .Rst(Rst), .b(b), .en(en), .pol(pol),
    .o(o1), .valid(v1), .sat(s1)
  );

  // Reference model: is a measurement open, its polarity, spaces seen so far
  // (unbounded), and whether the last consumed sample closed a measurement.
  bit         m_open [2];
  bit         m_apol [2];
  int         m_sp   [2];
  bit         m_rep  [2];
  logic       m_v    [2];
  logic [2:0] m_o    [2];
  logic       m_s    [2];

  function automatic void model_step(int c, logic r, logic e, logic p, logic bb);
    bit mk;
    m_v[c] = 1'b0;
    m_o[c] = 3'd0;
    m_s[c] = 1'b0;
    if (r) begin
      m_open[c] = 1'b0; m_apol[c] = 1'b1; m_sp[c] = 0; m_rep[c] = 1'b0;
      return;
    end
    if (!e) return;
    if (!m_open[c]) begin
      if (bb == p) begin
        m_open[c] = 1'b1; m_apol[c] = p; m_sp[c] = 0; m_rep[c] = 1'b0;
      end
      return;
    end
    mk = (bb == m_apol[c]);
    if (m_rep[c]) begin
      m_rep[c] = 1'b0;
      if (mk)        m_sp[c] = 0;
      else if (c==1) m_sp[c] = 1;
      else           m_open[c] = 1'b0;
    end else if (mk) begin
      if (m_sp[c] > 0) begin
        m_v[c]   = 1'b1;
        m_s[c]   = (m_sp[c] >= MAXG);
        m_o[c]   = m_s[c] ? 3'b111 : 3'(m_sp[c]);
        m_rep[c] = 1'b1;
        m_sp[c]  = 0;
      end
    end else begin
      m_sp[c] = m_sp[c] + 1;
    end
  endfunction

  function automatic void chk(string name, logic [2:0] act, logic [2:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endfunction

  // Apply one sample, clock it, then compare both DUTs with the model.
  task automatic cycle(input logic r, input logic e, input logic p, input logic bb);
    Rst = r; en = e; pol = p; b = bb;
    model_step(0, r, e, p, bb);
    model_step(1, r, e, p, bb);
    @(posedge Clk);
    #1;
    chk("model0_valid", {2'b0, v0}, {2'b0, m_v[0]});
    chk("model0_o",     o0,         m_o[0]);
    chk("model0_sat",   {2'b0, s0}, {2'b0, m_s[0]});
    chk("model1_valid", {2'b0, v1}, {2'b0, m_v[1]});
    chk("model1_o",     o1,         m_o[1]);
    chk("model1_sat",   {2'b0, s1}, {2'b0, m_s[1]});
  endtask

  typedef struct {
    logic       rst, en, pol, b;
    logic       v;
    logic [2:0] o;
    logic       s;
  } vec_t;

  vec_t tbl[$];

  function automatic void a(logic r, logic e, logic p, logic bb,
                            logic v, logic [2:0] oo, logic s);
    vec_t t;
    t.rst = r; t.en = e; t.pol = p; t.b = bb; t.v = v; t.o = oo; t.s = s;
    tbl.push_back(t);
  endfunction

  logic bs [6];
  logic ev [6];
  logic [2:0] eo [6];

  initial begin
    Rst = 1'b1; en = 1'b0; pol = 1'b1; b = 1'b0;

    // Reset, with en low and high.
    a(1,0,1,0, 0,0,0);  a(1,1,1,1, 0,0,0);
    // 1,0,0,1 -> o=2; trailing space returns to idle.
    a(0,1,1,1, 0,0,0); a(0,1,1,0, 0,0,0); a(0,1,1,0, 0,0,0); a(0,1,1,1, 1,2,0);
    a(0,1,1,0, 0,0,0);
    // 1,0x6,1 -> saturated, no intermediate report.
    a(0,1,1,1, 0,0,0);
    for (int i = 0; i < 6; i++) a(0,1,1,0, 0,0,0);
    a(0,1,1,1, 1,7,1); a(0,1,1,0, 0,0,0);
    // Boundary: 3 spaces -> o=3, 4 spaces -> saturated.
    a(0,1,1,1, 0,0,0); a(0,1,1,0, 0,0,0); a(0,1,1,0, 0,0,0); a(0,1,1,0, 0,0,0);
    a(0,1,1,1, 1,3,0); a(0,1,1,0, 0,0,0);
    a(0,1,1,1, 0,0,0);
    for (int i = 0; i < 4; i++) a(0,1,1,0, 0,0,0);
    a(0,1,1,1, 1,7,1); a(0,1,1,0, 0,0,0);
    // 0,0,1,1,1,0,1,0,1 -> one report o=1 on the 7th sample.
    a(0,1,1,0, 0,0,0); a(0,1,1,0, 0,0,0); a(0,1,1,1, 0,0,0); a(0,1,1,1, 0,0,0);
    a(0,1,1,1, 0,0,0); a(0,1,1,0, 0,0,0); a(0,1,1,1, 1,1,0); a(0,1,1,0, 0,0,0);
    a(0,1,1,1, 0,0,0);
    a(1,1,1,0, 0,0,0);
    // en=0 stall in the middle of a gap.
    a(0,1,1,1, 0,0,0); a(0,1,1,0, 0,0,0);
    a(0,0,1,1, 0,0,0); a(0,0,1,1, 0,0,0); a(0,0,1,1, 0,0,0);
    a(0,1,1,0, 0,0,0); a(0,1,1,1, 1,2,0); a(0,1,1,0, 0,0,0);
    // Reset mid-measurement discards it.
    a(0,1,1,1, 0,0,0); a(0,1,1,0, 0,0,0); a(0,1,1,0, 0,0,0); a(1,1,1,1, 0,0,0);
    a(0,1,1,1, 0,0,0); a(0,1,1,0, 0,0,0); a(0,1,1,1, 1,1,0); a(0,1,1,0, 0,0,0);
    // pol=0 measurement; pol toggling mid-measurement is ignored.
    a(0,1,0,0, 0,0,0); a(0,1,1,1, 0,0,0); a(0,1,1,1, 0,0,0); a(0,1,0,0, 1,2,0);
    a(0,1,1,1, 0,0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].rst, tbl[i].en, tbl[i].pol, tbl[i].b);
      chk("tbl_valid", {2'b0, v0}, {2'b0, tbl[i].v});
      chk("tbl_o",     o0,         tbl[i].o);
      chk("tbl_sat",   {2'b0, s0}, {2'b0, tbl[i].s});
    end

    // Chained measurements: 1,0,1,0,0,1 -> o=1 then o=2, both polarities.
    bs = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    ev = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    eo = '{3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd2};
    for (int p = 1; p >= 0; p--) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) begin
        cycle(1'b0, 1'b1, 1'(p), (p != 0) ? bs[i] : ~bs[i]);
        chk("chain_valid", {2'b0, v1}, {2'b0, ev[i]});
        chk("chain_o",     o1,         eo[i]);
        chk("chain_sat",   {2'b0, s1}, 3'd0);
      end
    end

    // Random stream with long space runs, stalls, polarity changes, resets.
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    begin
      logic rp;
      rp = 1'b1;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 15) == 0) rp = ~rp;
        cycle(($urandom_range(0, 99) == 0),
              ($urandom_range(0, 4) != 0),
              rp,
              ($urandom_range(0, 2) == 0) ? rp : ~rp);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
